// File: rtl/mul_eval_pkg.sv
// Shared definitions for the multiplier error-evaluation blocks: widths, FSM state, |a-b| helper.
package mul_eval_pkg;

    localparam int unsigned P_W   = 32;
    localparam int unsigned ACC_W = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [P_W-1:0] abs_diff(input logic [P_W-1:0] a, input logic [P_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ed_stage.sv
// Pipeline stage 1: registers the error distance |a-b| and the inequality flag of one sample.
module ed_stage
    import mul_eval_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [P_W-1:0] a,
    input  logic [P_W-1:0] b,
    output logic           out_valid,
    output logic [P_W-1:0] ed,
    output logic           neq
);

    logic           valid_q, valid_d;
    logic [P_W-1:0] ed_q, ed_d;
    logic           neq_q, neq_d;

    // Data only captured on a valid sample so idle cycles leave the registers quiet.
    always_comb begin
        valid_d = in_valid;
        ed_d    = ed_q;
        neq_d   = neq_q;
        if (in_valid) begin
            ed_d  = abs_diff(a, b);
            neq_d = (a != b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ed_q    <= '0;
            neq_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ed_q    <= ed_d;
            neq_q   <= neq_d;
        end
    end

    assign out_valid = valid_q;
    assign ed        = ed_q;
    assign neq       = neq_q;

endmodule

// File: rtl/mul_error_monitor.sv
// Accumulates error count, ED sum (saturating) and max ED over a run of N_SMP paired products.
module mul_error_monitor
    import mul_eval_pkg::*;
#(
    parameter int unsigned N_SMP = 16,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = mul_eval_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   p_exact,
    input  logic [P_W-1:0]   p_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [P_W-1:0]   max_ed,
    output logic [ACC_W-1:0] sum_ed
);

    localparam int unsigned SUM_W = ACC_W + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [P_W-1:0]   max_ed_q, max_ed_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [SUM_W-1:0] sum_ext;

    logic             accept;
    logic             launch;
    logic             s1_valid;
    logic [P_W-1:0]   s1_ed;
    logic             s1_neq;

    assign accept = in_valid & in_ready_q;

    ed_stage u_ed_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .a         (p_exact),
        .b         (p_approx),
        .out_valid (s1_valid),
        .ed        (s1_ed),
        .neq       (s1_neq)
    );

    // Run control; status outputs are registered from the next state.
    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        launch    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    acc_cnt_d = '0;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == CNT_W'(N_SMP - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            // The final sample sits in stage 1 here and lands in the accumulators on this edge.
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == RUN);
        busy_d     = (state_d == RUN) || (state_d == DRAIN);
        done_d     = (state_d == DONE);
    end

    // Stage 2: metric accumulation.
    always_comb begin
        smp_cnt_d = smp_cnt_q;
        err_cnt_d = err_cnt_q;
        max_ed_d  = max_ed_q;
        sum_ed_d  = sum_ed_q;
        sum_ext   = {1'b0, sum_ed_q} + SUM_W'(s1_ed);
        if (launch) begin
            smp_cnt_d = '0;
            err_cnt_d = '0;
            max_ed_d  = '0;
            sum_ed_d  = '0;
        end else if (s1_valid) begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
            err_cnt_d = err_cnt_q + CNT_W'(s1_neq);
            if (s1_ed > max_ed_q) begin
                max_ed_d = s1_ed;
            end
            sum_ed_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            smp_cnt_q  <= '0;
            err_cnt_q  <= '0;
            max_ed_q   <= '0;
            sum_ed_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            smp_cnt_q  <= smp_cnt_d;
            err_cnt_q  <= err_cnt_d;
            max_ed_q   <= max_ed_d;
            sum_ed_q   <= sum_ed_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign smp_cnt  = smp_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign max_ed   = max_ed_q;
    assign sum_ed   = sum_ed_q;

endmodule

// File: tb/tb_mul_error_monitor.sv
// Randomised and directed check of mul_error_monitor against a cycle-indexed list-based reference model.
module tb_mul_error_monitor;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned AW = 33;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   p_exact  = '0;
    logic [31:0]   p_approx = '0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] smp_cnt;
    logic [CW-1:0] err_cnt;
    logic [31:0]   max_ed;
    logic [AW-1:0] sum_ed;

    always #5 clk = ~clk;

    mul_error_monitor #(.N_SMP(N), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p_exact  (p_exact),
        .p_approx (p_approx),
        .busy     (busy),
        .done     (done),
        .smp_cnt  (smp_cnt),
        .err_cnt  (err_cnt),
        .max_ed   (max_ed),
        .sum_ed   (sum_ed)
    );

    int checks = 0;
    int errors = 0;

    // Model: cycle c observes outputs after edge c; inputs set in cycle c are sampled at edge c+1.
    int          cyc     = 0;
    bit          started = 1'b0;
    int          s_cyc   = 0;
    int          acc_cyc[$];
    logic [31:0] acc_ed[$];
    logic [31:0] q_e[$];
    logic [31:0] q_a[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [31:0] ed_of(input logic [31:0] e, input logic [31:0] a);
        longint d;
        d = longint'(e) - longint'(a);
        if (d < 0) d = -d;
        return d[31:0];
    endfunction

    function automatic bit m_done();
        return started && (acc_cyc.size() == N) && (cyc >= acc_cyc[N-1] + 2);
    endfunction

    function automatic bit m_ready();
        return started && (cyc >= s_cyc + 1) && (acc_cyc.size() < N);
    endfunction

    function automatic bit m_busy();
        return started && (cyc >= s_cyc + 1) && !m_done();
    endfunction

    task automatic m_metrics(output longint unsigned smp, output longint unsigned err,
                             output longint unsigned mx, output longint unsigned sum);
        longint unsigned cap;
        cap = (64'd1 << AW) - 64'd1;
        smp = 0; err = 0; mx = 0; sum = 0;
        foreach (acc_cyc[i]) begin
            if (acc_cyc[i] <= cyc - 2) begin
                smp++;
                if (acc_ed[i] != 0) err++;
                if (64'(acc_ed[i]) > mx) mx = 64'(acc_ed[i]);
                sum = sum + 64'(acc_ed[i]);
                if (sum > cap) sum = cap;
            end
        end
    endtask

    task automatic check_outputs();
        longint unsigned smp, err, mx, sum;
        m_metrics(smp, err, mx, sum);
        chk("in_ready", 64'(in_ready), 64'(m_ready()));
        chk("busy",     64'(busy),     64'(m_busy()));
        chk("done",     64'(done),     64'(m_done()));
        chk("smp_cnt",  64'(smp_cnt),  smp);
        chk("err_cnt",  64'(err_cnt),  err);
        chk("max_ed",   64'(max_ed),   mx);
        chk("sum_ed",   64'(sum_ed),   sum);
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input bit v, input logic [31:0] e, input logic [31:0] a, input bit st,
                        output bit accepted);
        bit rdy, honour;
        check_outputs();
        rdy      = m_ready();
        honour   = st && (!started || m_done());
        accepted = v && rdy;
        in_valid = v;
        p_exact  = e;
        p_approx = a;
        start    = st;
        if (accepted) begin
            acc_cyc.push_back(cyc);
            acc_ed.push_back(ed_of(e, a));
        end
        if (honour) begin
            acc_cyc.delete();
            acc_ed.delete();
            started = 1'b1;
            s_cyc   = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 1'b0, acc);
    endtask

    task automatic apply_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_smp_cnt"},  64'(smp_cnt),  64'd0);
        chk({tag, "_err_cnt"},  64'(err_cnt),  64'd0);
        chk({tag, "_max_ed"},   64'(max_ed),   64'd0);
        chk({tag, "_sum_ed"},   64'(sum_ed),   64'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1'b0;
        acc_cyc.delete();
        acc_ed.delete();
        cyc++;
    endtask

    // Start a run and feed q_e/q_a; finishes two cycles past done.
    task automatic drive_run(input bit rnd_valid, input bit rnd_start);
        bit acc, v, st;
        int idx;
        idx = 0;
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        for (int k = 0; k < 300 && idx < q_e.size(); k++) begin
            v  = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            st = rnd_start && ($urandom_range(0, 7) == 0);
            step(v, q_e[idx], q_a[idx], st, acc);
            if (acc) idx++;
        end
        chk("run_timeout", 64'(idx), 64'(q_e.size()));
        idle(2);
    endtask

    task automatic push_pair(input logic [31:0] e, input logic [31:0] a);
        q_e.push_back(e);
        q_a.push_back(a);
    endtask

    task automatic rand_pairs();
        logic [31:0] e, a;
        q_e.delete();
        q_a.delete();
        for (int i = 0; i < int'(N); i++) begin
            e = $urandom;
            case ($urandom_range(0, 3))
                0:       a = e;
                1:       a = e + 32'($urandom_range(0, 1000));
                2:       a = $urandom;
                default: a = e ^ (32'd1 << $urandom_range(0, 31));
            endcase
            push_pair(e, a);
        end
    endtask

    initial begin
        bit acc;

        // Reset state
        #2;
        chk("por_busy",    64'(busy),    64'd0);
        chk("por_sum_ed",  64'(sum_ed),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 1;
        idle(2);

        // Reset mid-run after 3 accepts
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd100 + 32'(i), 32'd7, 1'b0, acc);
        idle(2);
        apply_reset("rst_mid");
        idle(2);

        // Exact products: no error accumulated
        q_e.delete(); q_a.delete();
        push_pair(32'd1078980, 32'd1078980);
        push_pair(32'd5479448, 32'd5479448);
        push_pair(32'd4577430, 32'd4577430);
        push_pair(32'd2222, 32'd2222);
        drive_run(1'b0, 1'b0);
        chk("exact_smp",  64'(smp_cnt), 64'd4);
        chk("exact_err",  64'(err_cnt), 64'd0);
        chk("exact_max",  64'(max_ed),  64'd0);
        chk("exact_sum",  64'(sum_ed),  64'd0);
        chk("exact_done", 64'(done),    64'd1);

        // Start coincident with in_valid in DONE: sample not taken
        step(1'b1, 32'd50, 32'd0, 1'b1, acc);
        chk("start_cv_ready", 64'(in_ready), 64'd1);
        chk("start_cv_smp",   64'(smp_cnt),  64'd0);

        // Mixed errors
        apply_reset("rst_pre_mixed");
        q_e.delete(); q_a.delete();
        push_pair(32'd1078980, 32'd1078976);
        push_pair(32'd5479448, 32'd5479448);
        push_pair(32'd4577430, 32'd4577686);
        push_pair(32'd7, 32'd7);
        drive_run(1'b0, 1'b0);
        chk("mixed_err", 64'(err_cnt), 64'd2);
        chk("mixed_max", 64'(max_ed),  64'd256);
        chk("mixed_sum", 64'(sum_ed),  64'd260);

        // Flow control: in_valid held for 10 cycles
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, $urandom, 1'b0, acc);
        chk("flow_smp",   64'(smp_cnt),  64'(N));
        chk("flow_done",  64'(done),     64'd1);
        chk("flow_ready", 64'(in_ready), 64'd0);

        // Extremes
        q_e.delete(); q_a.delete();
        push_pair(32'hFFFF_FFFF, 32'd0);
        push_pair(32'd0, 32'hFFFF_FFFF);
        push_pair(32'd0, 32'd0);
        push_pair(32'd5, 32'd5);
        drive_run(1'b1, 1'b0);
        chk("ext_max", 64'(max_ed), 64'hFFFF_FFFF);
        chk("ext_sum", 64'(sum_ed), 64'h1_FFFF_FFFE);
        chk("ext_err", 64'(err_cnt), 64'd2);

        // Saturation of the ED sum
        q_e.delete(); q_a.delete();
        for (int i = 0; i < int'(N); i++) push_pair(32'hFFFF_FFFF, 32'd0);
        drive_run(1'b0, 1'b0);
        chk("sat_sum", 64'(sum_ed), 64'h1_FFFF_FFFF);

        // Restart: start in RUN ignored, start in DONE clears
        rand_pairs();
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        step(1'b1, q_e[0], q_a[0], 1'b0, acc);
        step(1'b1, q_e[1], q_a[1], 1'b0, acc);
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        step(1'b1, q_e[2], q_a[2], 1'b1, acc);
        step(1'b1, q_e[3], q_a[3], 1'b0, acc);
        idle(3);
        chk("restart_smp", 64'(smp_cnt), 64'(N));
        step(1'b0, 32'd0, 32'd0, 1'b1, acc);
        chk("restart_clr_smp", 64'(smp_cnt), 64'd0);
        chk("restart_clr_sum", 64'(sum_ed),  64'd0);
        chk("restart_busy",    64'(busy),    64'd1);
        for (int k = 0; k < 40 && acc_cyc.size() < N; k++) step(1'b1, $urandom, $urandom, 1'b0, acc);
        idle(3);

        // Randomised runs
        for (int r = 0; r < 12; r++) begin
            rand_pairs();
            drive_run(1'b1, 1'b1);
            idle(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
